// File: rtl/i2s_tx_sample_unpacker.sv
// i2s_tx_sample_unpacker: splits 32-bit uDMA TX words into 8/16/32-bit
// samples for the I2S TX channel and tracks channel underruns.
//
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   cfg_en_i             enable; low flushes buffered word and state
//   cfg_data_size_i      00=8b, 01=16b, 1x=32b
//   cfg_sign_ext_i       sign- (1) or zero- (0) extend narrow samples
//   cfg_clr_err_i        pulse; clears underrun sticky flag and counter
//   in_*                 uDMA word stream (valid/ready)
//   out_*                sample stream to channel (valid/ready)
//   underrun_o           one pulse per underrun cycle
//   underrun_sticky_o    held until cleared
//   underrun_cnt_o       saturating underrun count
module i2s_tx_sample_unpacker #(
  parameter int UNDERRUN_CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_en_i,
  input  logic [1:0]                cfg_data_size_i,
  input  logic                      cfg_sign_ext_i,
  input  logic                      cfg_clr_err_i,
  input  logic [31:0]               in_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [31:0]               out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      underrun_o,
  output logic                      underrun_sticky_o,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
);

  localparam logic [UNDERRUN_CNT_W-1:0] CNT_ONE = 1;

  logic [31:0]               r_word;
  logic                      r_full;
  logic [1:0]                r_idx;
  logic                      r_started;
  logic                      r_sticky;
  logic [UNDERRUN_CNT_W-1:0] r_cnt;

  logic        last;
  logic        take;
  logic        load;
  logic        under;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // ">=" style compare: if the size is changed mid-word, an index
  // beyond the new range still counts as last so the word flushes.
  always_comb begin
    last = 1'b1;
    case (cfg_data_size_i)
      2'b00:   last = (r_idx == 2'd3);
      2'b01:   last = (r_idx != 2'd0);
      default: last = 1'b1;
    endcase
  end

  always_comb begin
    byte_s     = r_word[{r_idx, 3'b000} +: 8];
    half_s     = r_idx[0] ? r_word[31:16] : r_word[15:0];
    out_data_o = r_word;
    case (cfg_data_size_i)
      2'b00:
        out_data_o = {{24{cfg_sign_ext_i & byte_s[7]}}, byte_s};
      2'b01:
        out_data_o = {{16{cfg_sign_ext_i & half_s[15]}}, half_s};
      default:
        out_data_o = r_word;
    endcase
  end

  assign out_valid_o = r_full;
  assign take        = r_full & out_ready_i;
  assign in_ready_o  = cfg_en_i & ~rst_i
                     & (~r_full | (take & last));
  assign load        = in_valid_i & in_ready_o;
  assign under       = cfg_en_i & r_started
                     & out_ready_i & ~r_full;

  assign underrun_o        = under;
  assign underrun_sticky_o = r_sticky;
  assign underrun_cnt_o    = r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_word    <= '0;
      r_full    <= 1'b0;
      r_idx     <= '0;
      r_started <= 1'b0;
    end else if (!cfg_en_i) begin
      r_full    <= 1'b0;
      r_idx     <= '0;
      r_started <= 1'b0;
    end else begin
      if (take)
        r_started <= 1'b1;
      if (load) begin
        r_word <= in_data_i;
        r_full <= 1'b1;
        r_idx  <= '0;
      end else if (take) begin
        if (last) begin
          r_full <= 1'b0;
          r_idx  <= '0;
        end else begin
          r_idx  <= r_idx + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (cfg_clr_err_i) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (under) begin
      r_sticky <= 1'b1;
      if (r_cnt != '1)
        r_cnt <= r_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_i2s_tx_sample_unpacker.sv
// Directed bench for i2s_tx_sample_unpacker.
// Second instance uses a 2-bit counter to exercise saturation.
module tb_i2s_tx_sample_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  size;
  logic        sign;
  logic        clr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        under;
  logic        sticky;
  logic [15:0] cnt;

  logic        in_ready2;
  logic [31:0] out_data2;
  logic        out_valid2;
  logic        under2;
  logic        sticky2;
  logic [1:0]  cnt2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  i2s_tx_sample_unpacker #(.UNDERRUN_CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(en),
    .cfg_data_size_i(size), .cfg_sign_ext_i(sign),
    .cfg_clr_err_i(clr), .in_data_i(in_data),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .underrun_o(under),
    .underrun_sticky_o(sticky), .underrun_cnt_o(cnt)
  );

  i2s_tx_sample_unpacker #(.UNDERRUN_CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(en),
    .cfg_data_size_i(size), .cfg_sign_ext_i(sign),
    .cfg_clr_err_i(clr), .in_data_i(in_data),
    .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .out_data_o(out_data2), .out_valid_o(out_valid2),
    .out_ready_i(out_ready), .underrun_o(under2),
    .underrun_sticky_o(sticky2), .underrun_cnt_o(cnt2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] w [8];
  int acc;
  int outs;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    w[0] = 32'h0123_4567; w[1] = 32'h89AB_CDEF;
    w[2] = 32'hDEAD_BEEF; w[3] = 32'h8000_0001;
    w[4] = 32'h7FFF_FFFE; w[5] = 32'hCAFE_F00D;
    w[6] = 32'h1111_1111; w[7] = 32'h2222_2222;

    rst = 1; en = 0; size = 0; sign = 0; clr = 0;
    in_data = 0; in_valid = 0; out_ready = 0;
    tick; tick;
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_data", out_data, 0);
    check("rst_under", {31'd0, under}, 0);
    check("rst_sticky", {31'd0, sticky}, 0);
    check("rst_cnt", {16'd0, cnt}, 0);
    en = 1; #1;
    check("rst_rdy", {31'd0, in_ready}, 0);
    tick;
    rst = 0;

    // 8-bit sign-extended
    size = 0; sign = 1;
    in_valid = 1; in_data = 32'h80FF_7F01; out_ready = 1;
    #1 check("t1_rdy0", {31'd0, in_ready}, 1);
    tick;
    in_valid = 0;
    #1 check("t1_v0", {31'd0, out_valid}, 1);
    check("t1_s0", out_data, 32'h0000_0001);
    check("t1_r0", {31'd0, in_ready}, 0);
    tick;
    #1 check("t1_s1", out_data, 32'h0000_007F);
    check("t1_r1", {31'd0, in_ready}, 0);
    tick;
    #1 check("t1_s2", out_data, 32'hFFFF_FFFF);
    check("t1_r2", {31'd0, in_ready}, 0);
    tick;
    #1 check("t1_s3", out_data, 32'hFFFF_FF80);
    check("t1_r3", {31'd0, in_ready}, 1);
    tick;
    out_ready = 0; en = 0;
    #1 check("t1_empty", {31'd0, out_valid}, 0);
    tick;
    en = 1;

    // 16-bit zero-extended, back-to-back words
    size = 1; sign = 0;
    in_valid = 1; in_data = 32'h8000_1234; out_ready = 1;
    #1 check("t2_rdy", {31'd0, in_ready}, 1);
    tick;
    in_data = 32'hABCD_0001;
    #1 check("t2_s0", out_data, 32'h0000_1234);
    check("t2_r0", {31'd0, in_ready}, 0);
    tick;
    #1 check("t2_s1", out_data, 32'h0000_8000);
    check("t2_r1", {31'd0, in_ready}, 1);
    tick;
    in_valid = 0;
    #1 check("t2_s2", out_data, 32'h0000_0001);
    check("t2_v2", {31'd0, out_valid}, 1);
    tick;
    #1 check("t2_s3", out_data, 32'h0000_ABCD);
    check("t2_v3", {31'd0, out_valid}, 1);
    tick;
    out_ready = 0; en = 0;
    #1 check("t2_empty", {31'd0, out_valid}, 0);
    tick;
    en = 1;

    // 32-bit, continuous input, toggling ready
    size = 2; acc = 0; outs = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1; in_data = w[acc];
      out_ready = (c % 2 == 0);
      #1;
      if (out_valid && out_ready) begin
        check("t3_word", out_data, w[outs]);
        outs++;
      end
      if (in_valid && in_ready) acc++;
      tick;
    end
    in_valid = 0;
    for (int c = 0; c < 4; c++) begin
      out_ready = out_valid;
      #1;
      if (out_valid && out_ready) begin
        check("t3_word", out_data, w[outs]);
        outs++;
      end
      tick;
    end
    out_ready = 0;
    check("t3_acc", acc, 6);
    check("t3_bal", outs, acc);
    check("t3_cnt", {16'd0, cnt}, 0);
    en = 0; tick; en = 1;

    // underrun counting, clear, saturation
    size = 1; sign = 0;
    clr = 1; tick; clr = 0;
    in_valid = 1; in_data = 32'h0002_0001; out_ready = 1;
    tick;
    in_valid = 0;
    #1 check("t4_s0", out_data, 32'h0000_0001);
    check("t4_u0", {31'd0, under}, 0);
    tick;
    #1 check("t4_s1", out_data, 32'h0000_0002);
    tick;
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_upulse", {31'd0, under}, 1);
      tick;
    end
    out_ready = 0;
    #1 check("t4_uoff", {31'd0, under}, 0);
    check("t4_cnt", {16'd0, cnt}, 3);
    check("t4_sticky", {31'd0, sticky}, 1);
    check("t4_cnt2", {30'd0, cnt2}, 3);
    clr = 1; tick; clr = 0;
    #1 check("t4_clrcnt", {16'd0, cnt}, 0);
    check("t4_clrsticky", {31'd0, sticky}, 0);
    out_ready = 1;
    repeat (5) tick;
    out_ready = 0;
    #1 check("t4_cnt5", {16'd0, cnt}, 5);
    check("t4_sat", {30'd0, cnt2}, 3);
    check("t4_sticky2", {31'd0, sticky2}, 1);
    out_ready = 1; clr = 1;
    #1 check("t4_uclr", {31'd0, under}, 1);
    tick;
    clr = 0; out_ready = 0;
    #1 check("t4_clrwin", {16'd0, cnt}, 0);
    check("t4_clrwin2", {30'd0, cnt2}, 0);
    check("t4_clrwins", {31'd0, sticky}, 0);
    en = 0; tick; en = 1;

    // enable drop mid-word
    size = 0; sign = 0;
    in_valid = 1; in_data = 32'h4433_2211; out_ready = 1;
    tick;
    in_valid = 0;
    #1 check("t5_s0", out_data, 32'h0000_0011);
    tick;
    #1 check("t5_s1", out_data, 32'h0000_0022);
    tick;
    en = 0; out_ready = 0;
    #1 check("t5_rdyoff", {31'd0, in_ready}, 0);
    tick;
    #1 check("t5_voff", {31'd0, out_valid}, 0);
    check("t5_rdyoff2", {31'd0, in_ready}, 0);
    en = 1; in_valid = 1; in_data = 32'h8877_6655;
    #1 check("t5_rdyon", {31'd0, in_ready}, 1);
    tick;
    in_valid = 0; out_ready = 1;
    #1 check("t5_new0", out_data, 32'h0000_0055);
    check("t5_newv", {31'd0, out_valid}, 1);
    tick;
    #1 check("t5_new1", out_data, 32'h0000_0066);
    out_ready = 0; en = 0;
    tick;
    en = 1;

    // reset mid-word
    size = 0; sign = 1;
    in_valid = 1; in_data = 32'hDDCC_BBAA; out_ready = 1;
    tick;
    in_valid = 0;
    repeat (4) tick;
    in_valid = 1; in_data = 32'h1122_3344;
    #1 check("t6_under", {31'd0, under}, 1);
    check("t6_rdy", {31'd0, in_ready}, 1);
    tick;
    in_valid = 0;
    #1 check("t6_s0", out_data, 32'h0000_0044);
    check("t6_cnt", {16'd0, cnt}, 1);
    tick;
    #1 check("t6_s1", out_data, 32'h0000_0033);
    rst = 1;
    #1 check("t6_rvalid", {31'd0, out_valid}, 0);
    check("t6_rdata", out_data, 0);
    check("t6_rrdy", {31'd0, in_ready}, 0);
    check("t6_runder", {31'd0, under}, 0);
    check("t6_rsticky", {31'd0, sticky}, 0);
    check("t6_rcnt", {16'd0, cnt}, 0);
    tick;
    rst = 0; in_valid = 1; in_data = 32'h0000_00C3;
    out_ready = 0;
    #1 check("t6_rdy2", {31'd0, in_ready}, 1);
    tick;
    in_valid = 0;
    #1 check("t6_first", out_data, 32'hFFFF_FFC3);
    check("t6_firstv", {31'd0, out_valid}, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sample_unpacker.md
Name: i2s_tx_sample_unpacker

Overview:
- Sits directly upstream of the I2S TX DSP channel, between the uDMA TX word stream and the channel's fifo_data/valid/ready interface.
- Splits each 32-bit uDMA word into 1, 2 or 4 audio samples (32/16/8-bit) and presents each sample right-aligned in 32 bits, zero- or sign-extended.
- Detects underruns: the channel requests a sample and none is available.
- Single clock domain, the same clock as the TX channel consumer.

Parameters:
- UNDERRUN_CNT_W, 16, width of the saturating underrun counter.

Ports:
- clk_i  in  1  block clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cfg_en_i  in  1  block enable; low flushes state.
- cfg_data_size_i  in  2  sample size: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = treated as 32-bit.
- cfg_sign_ext_i  in  1  1 = sign-extend 8/16-bit samples; 0 = zero-extend.
- cfg_clr_err_i  in  1  single-cycle pulse; clears the underrun counter and sticky flag.
- in_data_i  in  32  uDMA TX word.
- in_valid_i  in  1  word valid.
- in_ready_o  out  1  word accepted when in_valid_i & in_ready_o.
- out_data_o  out  32  right-aligned, extended sample.
- out_valid_o  out  1  sample valid.
- out_ready_i  in  1  consumer takes the sample when out_valid_o & out_ready_i.
- underrun_o  out  1  single-cycle pulse per underrun event.
- underrun_sticky_o  out  1  set on any underrun; held until cleared.
- underrun_cnt_o  out  UNDERRUN_CNT_W  saturating underrun count.

Behaviour:
- Reset values: r_word = 0, r_full = 0, r_idx = 0, r_started = 0, out_valid_o = 0, out_data_o = 0, in_ready_o = 0, underrun_o = 0, sticky = 0, count = 0.
- Samples per word N is 4, 2 or 1 for sizes 00, 01, 10/11. last = (r_idx == N-1).
- Sample k is taken from word bits [k*S + S-1 : k*S], where S is the sample size. Sample 0 is the LSBs.
- out_data_o is combinational from r_word and r_idx. Extension uses the slice MSB when cfg_sign_ext_i = 1; for 32-bit samples the word passes unchanged.
- out_valid_o = r_full.
- in_ready_o = cfg_en_i & (!r_full | (out_valid_o & out_ready_i & last)). This is combinational, with no dependency on in_valid_i.
- Accepting a word loads r_word, sets r_full and sets r_idx = 0.
- Latency: a word accepted on cycle t gives out_valid_o = 1 on cycle t+1. Back-to-back words stream with no bubble; at 32-bit size this is 1 sample per cycle.
- Output handshake when not last: r_idx increments and r_full holds.
- Output handshake when last: if a new word is accepted on the same edge, it loads as above. Otherwise r_full clears and r_idx returns to 0.
- r_started is set on the first output handshake after enable, and cleared when cfg_en_i = 0.
- Underrun condition: cfg_en_i & r_started & out_ready_i & !out_valid_o.
  - underrun_o pulses for one cycle per cycle in which the condition is true.
  - sticky is set.
  - count increments and saturates at all-ones (no wrap).
- Underrun before the first sample (r_started = 0) is ignored. This is the channel's initial-load window.
- cfg_clr_err_i clears sticky and count. If it coincides with an underrun, the clear wins and the count ends at 0.
- cfg_en_i = 0 behaviour:
  - Synchronously clears r_full, r_idx and r_started.
  - in_ready_o = 0 and out_valid_o = 0.
  - Any partially consumed word is discarded.
  - Error sticky and count are retained.
- cfg_data_size_i and cfg_sign_ext_i are only changed while cfg_en_i = 0. Behaviour on a mid-stream change is undefined but must not lock up: the next last condition still flushes the word.
- Asserting rst_i mid-operation returns every register to its reset value immediately. The first post-reset sample comes from a newly accepted word.

Test Plan:
- 8-bit, sign_ext = 1, word 0x80FF7F01, out_ready held 1: outputs 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80 on 4 consecutive cycles. in_ready_o is high only on the 4th cycle.
- 16-bit, sign_ext = 0, words 0x8000_1234 then 0xABCD_0001 back-to-back: samples 0x1234, 0x8000, 0x0001, 0xABCD with no bubble. The second word is accepted on the same edge as the last sample of the first.
- 32-bit, in_valid continuous, out_ready toggling 1/0: each word appears unchanged, one per ready cycle. No word is dropped or duplicated, and the accepted-word count equals the output count.
- Underrun: deliver 2 samples, then hold in_valid = 0 with out_ready = 1 for 3 cycles. Expect underrun_o high for 3 cycles, count = 3, sticky = 1. A cfg_clr_err_i pulse then gives count 0, sticky 0.
- Saturation at UNDERRUN_CNT_W = 2: 5 underrun cycles leave the count at 3.
- Enable drop: cfg_en_i goes low after sample 1 of an 8-bit word. Expect out_valid_o = 0 and in_ready_o = 0 next cycle. After re-enable, the first output is sample 0 of the next word. The same check with rst_i asserted mid-word returns all outputs to their reset values.
